// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seg7_bin_display slice.
//   - state_e      : controller states (IDLE, CONV, COMMIT)
//   - SEG_BLANK    : all segments off (active-low)
//   - SEG_DASH     : only segment g lit
//   - SEG_GLYPHS   : glyphs for decimal digits 0..9, index = digit value
//   - seg7_dec_limit(): largest value that fits in a given number of digits
// Segment bit order is g..a (bit 6 = g, bit 0 = a), active-low.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry k holds the glyph for digit k.
  localparam logic [9:0][6:0] SEG_GLYPHS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // 10^digits - 1; evaluated at elaboration for the overflow range check.
  function automatic logic [31:0] seg7_dec_limit(input int digits);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: combinational digit-to-segment decoder for one HEX display.
// Ports:
//   digit [3:0] : BCD digit; codes 10..15 are not digits and show blank
//   blank       : force the display off
//   dash        : force a dash (wins over blank and digit)
//   seg   [6:0] : active-low segments, bit order g..a
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  // Priority decode: dash, then blank, then the digit glyph.
  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SEG_GLYPHS[0];
        4'd1:    seg = SEG_GLYPHS[1];
        4'd2:    seg = SEG_GLYPHS[2];
        4'd3:    seg = SEG_GLYPHS[3];
        4'd4:    seg = SEG_GLYPHS[4];
        4'd5:    seg = SEG_GLYPHS[5];
        4'd6:    seg = SEG_GLYPHS[6];
        4'd7:    seg = SEG_GLYPHS[7];
        4'd8:    seg = SEG_GLYPHS[8];
        4'd9:    seg = SEG_GLYPHS[9];
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_bin_display.sv
// seg7_bin_display: binary-to-decimal driver for DIGITS active-low 7-segment
// displays. A value accepted over in_valid/in_ready is converted with a
// bit-serial double-dabble engine (one bit per cycle), then committed to the
// registered hex outputs together with a one-cycle done pulse.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   in_value : unsigned value to display (WIDTH bits)
//   in_valid : in_value is valid this cycle
//   in_ready : block is idle and will accept a value
//   done     : one-cycle pulse, hex has just been updated
//   overflow : last committed value exceeded 10^DIGITS-1
//   hex      : 7 segments per digit, digit i at hex[7*i+6:7*i], i=0 is LSD
// Parameters: WIDTH (1..32), DIGITS (1..6).
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_bin_display
  import seg7_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int BCD_W = 4 * DIGITS;
  // Range-check width: wide enough for both the input and the decimal limit.
  localparam int CW = ((WIDTH > BCD_W) ? WIDTH : BCD_W) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(seg7_dec_limit(DIGITS));
  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [5:0]             cnt_q, cnt_d;
  logic                   ovf_pend_q, ovf_pend_d;
  logic                   in_ready_q, in_ready_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;
  logic [7*DIGITS-1:0]    hex_q, hex_d;

  logic                   accept_s;
  logic [BCD_W-1:0]       adj_s;
  logic [BCD_W+WIDTH-1:0] cat_s;
  logic [DIGITS-1:0]      blank_s;
  logic [7*DIGITS-1:0]    glyph_seg_s;

  assign accept_s = in_valid && in_ready_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= 6'd0;
      ovf_pend_q <= 1'b0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      hex_q      <= {DIGITS{SEG_BLANK}};
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      hex_q      <= hex_d;
    end
  end

  // Next-state logic for the IDLE -> CONV -> COMMIT sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        if (cnt_q == CNT_LAST) begin
          state_d = COMMIT;
        end else begin
          state_d = CONV;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift left.
  always_comb begin
    adj_s = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
    // The bit leaving the top nibble is dropped; overflow is range-checked.
    cat_s = {adj_s, shift_q} << 1;
  end

  // Per-digit blanking mask applied at commit time.
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic seen_s;
  always_comb begin
    blank_s = '0;
    seen_s  = 1'b0;
    // Walk from the top digit down; digit 0 is never blanked.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        seen_s = 1'b1;
      end else begin
        seen_s = seen_s;
      end
      blank_s[i] = ~seen_s;
    end
  end
`else
  assign blank_s = '0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_glyph
      seg7_glyph u_glyph (
        .digit (bcd_q[4*gi +: 4]),
        .blank (blank_s[gi]),
        .dash  (ovf_pend_q),
        .seg   (glyph_seg_s[7*gi +: 7])
      );
    end
  endgenerate

  // Datapath and output next-state values per controller state.
  always_comb begin
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    hex_d      = hex_q;
    in_ready_d = (state_d == IDLE);
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          shift_d    = in_value;
          bcd_d      = '0;
          cnt_d      = 6'd0;
          ovf_pend_d = (CW'(in_value) > LIMIT);
        end else begin
          shift_d    = shift_q;
        end
      end
      CONV: begin
        bcd_d   = cat_s[BCD_W+WIDTH-1 -: BCD_W];
        shift_d = cat_s[WIDTH-1:0];
        cnt_d   = cnt_q + 6'd1;
      end
      COMMIT: begin
        hex_d  = glyph_seg_s;
        ovf_d  = ovf_pend_q;
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign in_ready = in_ready_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign hex      = hex_q;

endmodule

// File: doc/seg7_bin_display.md
Name: seg7_bin_display

Overview:
- Multi-digit decimal display driver. Accepts an unsigned binary value through a valid/ready handshake.
- Converts the value to BCD with a sequential double-dabble engine, one bit per cycle.
- Drives DIGITS active-low 7-segment HEX outputs from registers.
- Sits between datapath counters/results and the board HEX displays. Replaces hand-wired per-digit BCD decoding.

Parameters:
- WIDTH, 10, input value width in bits; legal range 1..32.
- DIGITS, 3, number of decimal digits/HEX displays driven; legal range 1..6.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_value  input  WIDTH  unsigned binary value to display.
- in_valid  input  1  in_value is valid this cycle.
- in_ready  output  1  block can accept a value (state IDLE).
- done  output  1  one-cycle pulse when hex has just been updated.
- overflow  output  1  last committed value exceeded 10^DIGITS-1 (registered).
- hex  output  7*DIGITS  segments, digit i at hex[7*i+6:7*i], i=0 least significant; active-low, bit order g..a.

Behaviour:
- Clocking and reset: one clock (clk). reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE; in_ready=1; done=0; overflow=0; every hex digit = SEG_BLANK (7'b1111111). Internal shift and BCD registers are cleared to 0.
- Glyph encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; SEG_DASH=0111111.
- Accept: a transfer occurs on an edge where in_valid && in_ready.
  - in_value is latched into the shift register.
  - BCD register (4*DIGITS bits) is cleared and bit counter set to 0.
  - ovf_pending = (in_value > 10^DIGITS-1). Compare at max(WIDTH, 4*DIGITS)+1 bits; constant computed at elaboration.
  - Next state is CONV.
- State machine:
  - IDLE: in_ready=1. On accept go to CONV; otherwise hold. hex, overflow and done=0 are held.
  - CONV: in_ready=0. Each cycle:
    - every BCD nibble >= 5 gets +3 (all nibbles in parallel);
    - {bcd, shift} shifts left by 1;
    - counter increments.
    - After the WIDTH-th shift, go to COMMIT.
  - COMMIT: in_ready=0. Register hex/overflow from bcd and ovf_pending, set done=1, go to IDLE.
- Latency: accept at edge N; new hex, overflow and done=1 are all visible after edge N+WIDTH+1. done returns low after edge N+WIDTH+2.
- Throughput: one value per WIDTH+2 cycles. in_ready rises in the cycle done is high, so back-to-back accepts are legal.
- Overflow: if ovf_pending, all digits show SEG_DASH and overflow=1; otherwise overflow=0.
- Unused BCD bits: BCD bits beyond DIGITS are discarded. Overflow is covered by the range check, not by carry-out.
- in_valid while in_ready=0: ignored, with no side effect. Upstream must hold in_value until accepted.
- Reset mid-conversion: aborts immediately and returns to reset values; no done pulse is produced.
- Reset and in_valid in the same cycle: reset wins; the value is not accepted.
- WIDTH=1: exactly 1 CONV cycle.
- Input 0: shows all zeros (see optional feature).

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: at COMMIT, every digit above the most significant nonzero digit is driven SEG_BLANK. Digit 0 always shows its value (0 shows as a single "0"). No effect when overflow=1 (all digits show dashes).
- Undefined: all DIGITS digits are shown, including leading zeros.
- Latency and handshake are identical either way.

Decomposition:
- Package seg7_pkg:
  - state enum {IDLE, CONV, COMMIT};
  - SEG_BLANK and SEG_DASH constants;
  - 10-entry digit glyph constant array;
  - function for the 10^DIGITS-1 limit.
- Sub-module seg7_glyph: combinational; inputs digit[3:0], blank, dash; output seg[6:0].
  - Priority: dash > blank > digit.
  - Digits 10..15 map to SEG_BLANK.
  - Instantiated DIGITS times via generate.

Test Plan:
- Reset then idle: hex all 7'b1111111, in_ready=1, done=0; hold 5 cycles with in_valid=0; no change.
- Basic conversion: accept 937 at edge N (WIDTH=10, DIGITS=3).
  - done=1 exactly after edge N+11, for one cycle.
  - hex = {0010000, 0110000, 1111000}, overflow=0.
- Boundaries:
  - 999 -> all 0010000, overflow=0.
  - 1000 and 1023 -> all 0111111, overflow=1.
  - 0 -> all 1000000 (with macro: 1111111, 1111111, 1000000).
  - 5 with macro -> blank, blank, 0010010.
- Handshake:
  - Hold in_valid=1 with a value changing every cycle: only values present when in_ready=1 are taken; accepts are spaced exactly 12 cycles apart.
  - Back-to-back 12 then 345 -> hex shows 012 then 345.
- Reset mid-operation: accept 500, assert reset at cycle N+4 -> hex blank next edge, no done pulse; then accept 42 -> normal result 042 after 11 cycles.
